// File: rtl/move_clk_gen_if.sv
// Control/status bundle for move_clk_gen: cabin control inputs in, move clock and FSM status out.
interface move_clk_gen_if #(
  parameter int NUM_BUTTONS = 3
);
  logic [NUM_BUTTONS-1:0] call_btn;
  logic                   enable;
  logic                   moving;
  logic                   approach;
  logic                   sos_mode;
  logic                   weight_limit_exceeded;
  logic                   move_clk;
  logic                   move_tick;
  logic [1:0]             state;
  logic                   halted;

  modport master (
    output call_btn, enable, moving, approach, sos_mode, weight_limit_exceeded,
    input  move_clk, move_tick, state, halted
  );

  modport slave (
    input  call_btn, enable, moving, approach, sos_mode, weight_limit_exceeded,
    output move_clk, move_tick, state, halted
  );
endinterface

// File: rtl/move_clk_gen.sv
// Elevator movement clock: square wave with selectable half-period, held on halt,
// phase-restarted by a call-button press while the cabin is stationary.
module move_clk_gen #(
  parameter int MOVE_TIME   = 10,
  parameter int SLOW_TIME   = 20,
  parameter int NUM_BUTTONS = 3,
  parameter int CNT_W       = 26
) (
  input  logic           clk,
  input  logic           rst_n,
  move_clk_gen_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  state_t                 st;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_BUTTONS-1:0] btn_prev;
  logic                   mclk_q;
  logic                   tick_q;
  logic                   halted_q;

  logic             press;
  logic             halt;
  logic [CNT_W-1:0] limit;

  // Any high-to-low edge on the active-low buttons counts as a single press.
  assign press = |(btn_prev & ~bus.call_btn);
  assign halt  = bus.sos_mode | bus.weight_limit_exceeded;
  assign limit = bus.approach ? CNT_W'(SLOW_TIME) : CNT_W'(MOVE_TIME);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      cnt      <= '0;
      btn_prev <= '1;
      mclk_q   <= 1'b0;
      tick_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      btn_prev <= bus.call_btn;
      if (!bus.enable) begin
        st       <= IDLE;
        cnt      <= '0;
        mclk_q   <= 1'b0;
        tick_q   <= 1'b0;
        halted_q <= 1'b0;
      end else if (halt) begin
        // cnt and move_clk freeze so RUN resumes mid-period.
        st       <= HOLD;
        tick_q   <= 1'b0;
        halted_q <= 1'b1;
      end else begin
        st       <= RUN;
        halted_q <= 1'b0;
        if (press && !bus.moving) begin
          cnt    <= '0;
          mclk_q <= 1'b0;
          tick_q <= 1'b0;
        end else if (cnt >= limit) begin
          // >= lets a shortened limit take effect at once instead of wrapping.
          cnt    <= '0;
          mclk_q <= ~mclk_q;
          tick_q <= 1'b1;
        end else begin
          cnt    <= cnt + 1'b1;
          tick_q <= 1'b0;
        end
      end
    end
  end

  assign bus.move_clk  = mclk_q;
  assign bus.move_tick = tick_q;
  assign bus.state     = st;
  assign bus.halted    = halted_q;
endmodule

// File: tb/tb_move_clk_gen.sv
// Directed bench for move_clk_gen with MOVE_TIME=4, SLOW_TIME=8, NUM_BUTTONS=3.
module tb_move_clk_gen;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  move_clk_gen_if #(.NUM_BUTTONS(3)) bus ();

  move_clk_gen #(
    .MOVE_TIME(4), .SLOW_TIME(8), .NUM_BUTTONS(3), .CNT_W(26)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] st, input logic mc,
                         input logic tk, input logic hl);
    chk({tag, ".state"},  32'(bus.state),     32'(st));
    chk({tag, ".mclk"},   32'(bus.move_clk),  32'(mc));
    chk({tag, ".tick"},   32'(bus.move_tick), 32'(tk));
    chk({tag, ".halted"}, 32'(bus.halted),    32'(hl));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.call_btn = 3'b111;
    bus.enable = 1'b0;
    bus.moving = 1'b0;
    bus.approach = 1'b0;
    bus.sos_mode = 1'b0;
    bus.weight_limit_exceeded = 1'b0;
    #1;
    chk_out("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.cnt", 32'(dut.cnt), 32'd0);
    #12 rst_n = 1'b1;
    step(2);
    chk_out("idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // Normal speed: toggle every 5 cycles, full period 10.
    bus.enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk($sformatf("norm%0d.mclk", k), 32'(bus.move_clk), 32'((k >= 5 && k < 10) ? 1 : 0));
      chk($sformatf("norm%0d.tick", k), 32'(bus.move_tick), 32'((k == 5 || k == 10) ? 1 : 0));
    end
    chk("norm.state", 32'(bus.state), 32'd1);

    // Approach speed: toggle every 9 cycles.
    bus.approach = 1'b1;
    step(8);
    chk_out("slow8", 2'd1, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_out("slow9", 2'd1, 1'b1, 1'b1, 1'b0);
    step(6);
    chk("slow.cnt6", 32'(dut.cnt), 32'd6);
    bus.approach = 1'b0;
    step(1);
    chk_out("shorten", 2'd1, 1'b0, 1'b1, 1'b0);
    chk("shorten.cnt", 32'(dut.cnt), 32'd0);

    // Emergency hold at cnt=2 for 7 cycles.
    step(2);
    chk("sos.cnt2", 32'(dut.cnt), 32'd2);
    bus.sos_mode = 1'b1;
    step(1);
    chk_out("sos1", 2'd2, 1'b0, 1'b0, 1'b1);
    bus.call_btn = 3'b110;
    step(6);
    chk_out("sos7", 2'd2, 1'b0, 1'b0, 1'b1);
    chk("sos7.cnt", 32'(dut.cnt), 32'd2);
    bus.sos_mode = 1'b0;
    bus.call_btn = 3'b111;
    step(2);
    chk_out("resume2", 2'd1, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_out("resume3", 2'd1, 1'b1, 1'b1, 1'b0);

    // Press while stationary restarts the phase; two falling bits count once.
    step(3);
    chk("press.cnt3", 32'(dut.cnt), 32'd3);
    bus.call_btn = 3'b101;
    step(1);
    chk_out("press", 2'd1, 1'b0, 1'b0, 1'b0);
    chk("press.cnt", 32'(dut.cnt), 32'd0);
    bus.call_btn = 3'b111;
    step(3);
    chk("pressmv.cnt3", 32'(dut.cnt), 32'd3);
    bus.moving = 1'b1;
    bus.call_btn = 3'b100;
    step(1);
    chk("pressmv.cnt", 32'(dut.cnt), 32'd4);
    step(1);
    chk_out("pressmv.tog", 2'd1, 1'b1, 1'b1, 1'b0);
    bus.moving = 1'b0;
    bus.call_btn = 3'b111;

    // Disable mid-run with move_clk high; halts ignored while disabled.
    step(1);
    bus.enable = 1'b0;
    step(1);
    chk_out("dis", 2'd0, 1'b0, 1'b0, 1'b0);
    chk("dis.cnt", 32'(dut.cnt), 32'd0);
    bus.sos_mode = 1'b1;
    bus.weight_limit_exceeded = 1'b1;
    step(2);
    chk_out("dishalt", 2'd0, 1'b0, 1'b0, 1'b0);
    bus.sos_mode = 1'b0;
    bus.enable = 1'b1;
    step(1);
    chk_out("weight", 2'd2, 1'b0, 1'b0, 1'b1);
    bus.weight_limit_exceeded = 1'b0;
    step(1);
    chk("weightrel.cnt", 32'(dut.cnt), 32'd1);

    // Asynchronous reset mid-period with move_clk high.
    step(4);
    chk_out("prerst", 2'd1, 1'b1, 1'b1, 1'b0);
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk_out("asyncrst", 2'd0, 1'b0, 1'b0, 1'b0);
    chk("asyncrst.cnt", 32'(dut.cnt), 32'd0);
    #2 rst_n = 1'b1;
    step(4);
    chk_out("rerun4", 2'd1, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_out("rerun5", 2'd1, 1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
